// File: rtl/ascensor_pkg.sv
// ascensor_pkg
// Shared definitions for the elevator cabin controller and the floor-request
// queue: controller state encoding, floor width and default floor count.
`timescale 1ns/1ps
package ascensor_pkg;

  // Width of every floor number in the system.
  localparam int ANCHO_PISO = 4;

  // Default number of valid floors. The request queue depth uses the same value.
  localparam int NUM_PISOS_DEF = 11;

  typedef enum logic [2:0] {
    REPOSO = 3'd0,
    EVALUA = 3'd1,
    SUBE   = 3'd2,
    BAJA   = 3'd3,
    PUERTA = 3'd4
  } estado_t;

endpackage

// File: rtl/temporizador_intervalo.sv
// temporizador_intervalo
// Interval counter shared by travel and door timing. It counts up while
// enabled and wraps to zero when it reaches the supplied terminal value.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   i_clr       synchronous clear (has priority over the enable)
//   i_en        count enable; low freezes the count (emergency stop)
//   i_ultimo    terminal value (interval length minus one)
//   o_fin       high in the enabled cycle where the count equals i_ultimo
`timescale 1ns/1ps
module temporizador_intervalo #(
  parameter int ANCHO = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [ANCHO-1:0] i_ultimo,
  output logic             o_fin
);

  logic [ANCHO-1:0] r_cuenta;

  // The flag is qualified by the enable so a frozen counter never ends an interval.
  assign o_fin = i_en && (r_cuenta == i_ultimo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cuenta <= '0;
    end else if (i_clr) begin
      r_cuenta <= '0;
    end else if (i_en) begin
      if (o_fin) r_cuenta <= '0;
      else       r_cuenta <= r_cuenta + {{(ANCHO-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/control_cabina.sv
// control_cabina
// Cabin motion controller. It takes one request from the queue head and
// pops it. It moves the cabin one floor per travel interval toward the
// requested floor, then holds the door open for the door interval.
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   i_sol_valida       queue head holds a valid request
//   i_sol_piso         requested floor at the queue head
//   i_parada           emergency stop; freezes motion and door timing
//   o_sol_tomar        one-cycle pop strobe to the queue
//   o_piso_actual      current cabin floor
//   o_subiendo         cabin travelling up
//   o_bajando          cabin travelling down
//   o_puerta_abierta   door open
//   o_ocupado          controller busy (any state other than REPOSO)
//   o_error_piso       one-cycle pulse for an out-of-range request
// All outputs are registered.
`timescale 1ns/1ps
module control_cabina
  import ascensor_pkg::*;
#(
  parameter int NUM_PISOS    = NUM_PISOS_DEF,
  parameter int TICKS_PISO   = 50000000,
  parameter int TICKS_PUERTA = 100000000,
  parameter int ANCHO_CONT   = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_sol_valida,
  input  logic [ANCHO_PISO-1:0] i_sol_piso,
  input  logic                  i_parada,
  output logic                  o_sol_tomar,
  output logic [ANCHO_PISO-1:0] o_piso_actual,
  output logic                  o_subiendo,
  output logic                  o_bajando,
  output logic                  o_puerta_abierta,
  output logic                  o_ocupado,
  output logic                  o_error_piso
);

  localparam logic [ANCHO_PISO-1:0] UNO_PISO = {{(ANCHO_PISO-1){1'b0}}, 1'b1};

  estado_t               r_estado, w_estado_next;
  logic [ANCHO_PISO-1:0] r_piso, w_piso_next;
  logic [ANCHO_PISO-1:0] r_destino, w_destino_next;
  logic                  w_tomar_next, w_error_next;

  logic                  w_fin, w_en, w_clr;
  logic [ANCHO_CONT-1:0] w_ultimo;

  // The one counter times either a floor step or the door; the state selects the length.
  assign w_ultimo = (r_estado == PUERTA) ? ANCHO_CONT'(TICKS_PUERTA - 1)
                                         : ANCHO_CONT'(TICKS_PISO - 1);
  assign w_en  = !i_parada && ((r_estado == SUBE) || (r_estado == BAJA) || (r_estado == PUERTA));
  assign w_clr = (r_estado == REPOSO) || (r_estado == EVALUA);

  temporizador_intervalo #(.ANCHO(ANCHO_CONT)) u_temporizador (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_clr),
    .i_en     (w_en),
    .i_ultimo (w_ultimo),
    .o_fin    (w_fin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado         <= REPOSO;
      r_piso           <= '0;
      r_destino        <= '0;
      o_sol_tomar      <= 1'b0;
      o_subiendo       <= 1'b0;
      o_bajando        <= 1'b0;
      o_puerta_abierta <= 1'b0;
      o_ocupado        <= 1'b0;
      o_error_piso     <= 1'b0;
    end else begin
      r_estado         <= w_estado_next;
      r_piso           <= w_piso_next;
      r_destino        <= w_destino_next;
      o_sol_tomar      <= w_tomar_next;
      o_error_piso     <= w_error_next;
      // Status flags follow the next state, so they line up with the state they describe.
      o_subiendo       <= (w_estado_next == SUBE);
      o_bajando        <= (w_estado_next == BAJA);
      o_puerta_abierta <= (w_estado_next == PUERTA);
      o_ocupado        <= (w_estado_next != REPOSO);
    end
  end

  assign o_piso_actual = r_piso;

  always_comb begin
    w_estado_next  = r_estado;
    w_piso_next    = r_piso;
    w_destino_next = r_destino;
    w_tomar_next   = 1'b0;
    w_error_next   = 1'b0;
    case (r_estado)
      REPOSO: begin
        if (i_sol_valida) begin
          w_destino_next = i_sol_piso;
          w_tomar_next   = 1'b1;
          w_estado_next  = EVALUA;
        end
      end
      EVALUA: begin
        // Rejecting out-of-range floors here keeps the floor register in range.
        if (int'(r_destino) >= NUM_PISOS) begin
          w_error_next  = 1'b1;
          w_estado_next = REPOSO;
        end else if (r_destino == r_piso) begin
          w_estado_next = PUERTA;
        end else if (r_destino > r_piso) begin
          w_estado_next = SUBE;
        end else begin
          w_estado_next = BAJA;
        end
      end
      SUBE: begin
        if (w_fin) begin
          w_piso_next = r_piso + UNO_PISO;
          if (w_piso_next == r_destino) w_estado_next = PUERTA;
        end
      end
      BAJA: begin
        if (w_fin) begin
          w_piso_next = r_piso - UNO_PISO;
          if (w_piso_next == r_destino) w_estado_next = PUERTA;
        end
      end
      PUERTA: begin
        if (w_fin) w_estado_next = REPOSO;
      end
      default: w_estado_next = REPOSO;
    endcase
  end

endmodule
